fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-source EX-stage forwarding unit.
- Selects operand-A and operand-B bypass sources from NSRC younger pipeline stages, with strict youngest-first priority.
- Detects load-use hazards in ID and drives a multi-cycle stall/bubble FSM, so loads with latency >1 cycle are supported.
- Sits between the ID/EX register and the EX operand muxes; its stall outputs go to the PC, IF/ID and ID/EX control.

---
 rtl/fwd_hazard_unit.sv | 117 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding across NSRC younger stages plus load-use stall/bubble control.
// Optional build macro FWD_STATS_EN adds saturating forwarding/stall event counters.
module fwd_hazard_unit #(
    parameter int unsigned NSRC               = 2,
    parameter int unsigned REG_AW             = 5,
    parameter int unsigned LOAD_LAT           = 1,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1,
    localparam int unsigned SELW              = $clog2(NSRC + 1),
    localparam int unsigned CNTW              = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_AW-1:0]        ex_rs,
    input  logic [REG_AW-1:0]        ex_rt,
    input  logic [NSRC*REG_AW-1:0]   src_rd,
    input  logic [NSRC-1:0]          src_we,
    input  logic [REG_AW-1:0]        id_rs,
    input  logic [REG_AW-1:0]        id_rt,
    input  logic                     id_use_rs,
    input  logic                     id_use_rt,
    input  logic                     ex_mem_read,
    input  logic [REG_AW-1:0]        ex_rd,
    input  logic                     flush,
    output logic [SELW-1:0]          a_sel,
    output logic [SELW-1:0]          b_sel,
    output logic                     stall,
`ifdef FWD_STATS_EN
    output logic                     id_ex_bubble,
    output logic [31:0]              fwd_cnt,
    output logic [31:0]              stall_cnt
`else
    output logic                     id_ex_bubble
`endif
);

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    state_t            stateQ;
    logic [CNTW-1:0]   cntQ;
    logic [SELW-1:0]   aSelRaw;
    logic [SELW-1:0]   bSelRaw;
    logic              haz;
    logic              stallRaw;

    // Iterate oldest to youngest so the lowest matching index is the final assignment.
    always_comb begin
        aSelRaw = '0;
        bSelRaw = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (src_we[i] && src_rd[i*REG_AW +: REG_AW] == ex_rs &&
                (ex_rs != '0 || !ZERO_REG_HARDWIRED)) begin
                aSelRaw = SELW'(i + 1);
            end
            if (src_we[i] && src_rd[i*REG_AW +: REG_AW] == ex_rt &&
                (ex_rt != '0 || !ZERO_REG_HARDWIRED)) begin
                bSelRaw = SELW'(i + 1);
            end
        end
    end

    always_comb begin
        haz = ex_mem_read && (LOAD_LAT != 0) && (ex_rd != '0 || !ZERO_REG_HARDWIRED) &&
              ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        stallRaw = !flush && (stateQ == StHold || haz);
    end

    assign a_sel        = rst ? aSelRaw : '0;
    assign b_sel        = rst ? bSelRaw : '0;
    assign stall        = rst && stallRaw;
    assign id_ex_bubble = rst && stallRaw;

    // The IDLE cycle that detects the hazard is the first stall cycle; HOLD covers the rest.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (haz && LOAD_LAT > 1) begin
                        stateQ <= StHold;
                        cntQ   <= CNTW'(LOAD_LAT - 1);
                    end
                end
                StHold: begin
                    if (cntQ == CNTW'(1)) begin
                        stateQ <= StIdle;
                        cntQ   <= '0;
                    end else begin
                        cntQ <= cntQ - CNTW'(1);
                    end
                end
                default: begin
                    stateQ <= StIdle;
                    cntQ   <= '0;
                end
            endcase
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((a_sel != '0 || b_sel != '0) && !stall && fwd_cnt != 32'hFFFF_FFFF) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
            if (stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: dutA (LOAD_LAT=3, zero reg hardwired) and dutB (LOAD_LAT=1, zero reg live)
// share one set of stimulus; expected values are hand-computed.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  exRs, exRt, idRs, idRt, exRd;
    logic [9:0]  srcRd;
    logic [1:0]  srcWe;
    logic        idUseRs, idUseRt, exMemRead, flush;
    logic [1:0]  aSelA, bSelA, aSelB, bSelB;
    logic        stallA, bubA, stallB, bubB;
`ifdef FWD_STATS_EN
    logic [31:0] fwdCntA, stallCntA, fwdCntB, stallCntB;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NSRC(2), .REG_AW(5), .LOAD_LAT(3), .ZERO_REG_HARDWIRED(1'b1)) dutA (
        .clk(clk), .rst(rst), .ex_rs(exRs), .ex_rt(exRt), .src_rd(srcRd), .src_we(srcWe),
        .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
        .ex_mem_read(exMemRead), .ex_rd(exRd), .flush(flush),
        .a_sel(aSelA), .b_sel(bSelA), .stall(stallA),
`ifdef FWD_STATS_EN
        .id_ex_bubble(bubA), .fwd_cnt(fwdCntA), .stall_cnt(stallCntA)
`else
        .id_ex_bubble(bubA)
`endif
    );

    fwd_hazard_unit #(.NSRC(2), .REG_AW(5), .LOAD_LAT(1), .ZERO_REG_HARDWIRED(1'b0)) dutB (
        .clk(clk), .rst(rst), .ex_rs(exRs), .ex_rt(exRt), .src_rd(srcRd), .src_we(srcWe),
        .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
        .ex_mem_read(exMemRead), .ex_rd(exRd), .flush(flush),
        .a_sel(aSelB), .b_sel(bSelB), .stall(stallB),
`ifdef FWD_STATS_EN
        .id_ex_bubble(bubB), .fwd_cnt(fwdCntB), .stall_cnt(stallCntB)
`else
        .id_ex_bubble(bubB)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearHaz();
        exMemRead = 1'b0; exRd = '0; idRs = '0; idRt = '0; idUseRs = 1'b0; idUseRt = 1'b0;
    endtask

    task automatic setHaz();
        exMemRead = 1'b1; exRd = 5'd5; idRt = 5'd5; idUseRt = 1'b1;
    endtask

    initial begin
        // Reset with every input pointing at a match: outputs must stay quiet.
        rst = 1'b0; flush = 1'b0;
        exRs = 5'd3; exRt = 5'd3; srcRd = {5'd3, 5'd3}; srcWe = 2'b11;
        clearHaz(); setHaz();
        tick(); tick();
        check("rst_a_sel", 32'(aSelA), 0);
        check("rst_b_sel", 32'(bSelB), 0);
        check("rst_stall", 32'(stallA), 0);
        check("rst_bubble", 32'(bubB), 0);
        clearHaz();
        rst = 1'b1;
        tick();

        // Forwarding priority and masking
        srcWe = 2'b11; #1;
        check("fwd_youngest", 32'(aSelA), 1);
        srcWe = 2'b10; #1;
        check("fwd_older", 32'(aSelA), 2);
        srcWe = 2'b00; #1;
        check("fwd_masked", 32'(aSelA), 0);
        exRs = 5'd3; exRt = 5'd7; srcRd = {5'd7, 5'd3}; srcWe = 2'b11; #1;
        check("fwd_a_indep", 32'(aSelA), 1);
        check("fwd_b_indep", 32'(bSelA), 2);
        exRs = 5'd4; exRt = 5'd4; srcRd = {5'd9, 5'd4}; #1;
        check("fwd_same_a", 32'(aSelA), 1);
        check("fwd_same_b", 32'(bSelA), 1);
        exRs = 5'd0; exRt = 5'd1; srcRd = {5'd9, 5'd0}; srcWe = 2'b01; #1;
        check("zero_hardwired", 32'(aSelA), 0);
        check("zero_live", 32'(aSelB), 1);
        srcWe = 2'b00; exRs = 5'd0; exRt = 5'd0; #1;

        // Hazard qualifiers (combinational only, cleared before the next edge)
        exMemRead = 1'b1; exRd = 5'd5; idRt = 5'd5; idUseRt = 1'b0; #1;
        check("haz_unused_rt", 32'(stallB), 0);
        idUseRs = 1'b1; idRs = 5'd5; #1;
        check("haz_rs", 32'(stallB), 1);
        exRd = 5'd0; idRs = 5'd0; #1;
        check("haz_zero_hw", 32'(stallA), 0);
        check("haz_zero_live", 32'(stallB), 1);
        clearHaz(); #1;

        // One-cycle hazard pulse: B stalls 1 cycle, A stalls 3 cycles
        tick();
        setHaz(); #1;
        check("pulse_c1_a", 32'(stallA), 1);
        check("pulse_c1_bub_a", 32'(bubA), 1);
        check("pulse_c1_b", 32'(stallB), 1);
        tick(); clearHaz(); #1;
        check("pulse_c2_a", 32'(stallA), 1);
        check("pulse_c2_b", 32'(stallB), 0);
        tick();
        check("pulse_c3_a", 32'(bubA), 1);
        tick();
        check("pulse_end_a", 32'(stallA), 0);
        tick();
        check("pulse_after_a", 32'(stallA), 0);

        // Flush in the second stall cycle aborts immediately
        setHaz(); #1;
        check("flush_c1", 32'(stallA), 1);
        tick(); clearHaz(); flush = 1'b1; #1;
        check("flush_c2", 32'(stallA), 0);
        check("flush_c2_bub", 32'(bubA), 0);
        tick(); flush = 1'b0; #1;
        check("flush_c3", 32'(stallA), 0);
        tick();
        check("flush_c4", 32'(stallA), 0);

        // Reset during HOLD, then a fresh full stall
        setHaz(); #1;
        tick(); clearHaz(); rst = 1'b0; #1;
        check("rst_hold_comb", 32'(stallA), 0);
        tick(); rst = 1'b1; #1;
        check("rst_hold_idle", 32'(stallA), 0);
        setHaz(); #1;
        check("fresh_c1", 32'(stallA), 1);
        tick(); clearHaz(); #1;
        check("fresh_c2", 32'(stallA), 1);
        tick();
        check("fresh_c3", 32'(stallA), 1);
        tick();
        check("fresh_end", 32'(stallA), 0);

`ifdef FWD_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1; #1;
        check("stats_rst_fwd", fwdCntA, 0);
        check("stats_rst_stall", stallCntA, 0);
        exRs = 5'd3; srcRd = {5'd0, 5'd3}; srcWe = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        srcWe = 2'b00; exRs = 5'd0;
        setHaz();
        tick(); clearHaz();
        tick(); tick(); tick();
        check("stats_fwd", fwdCntA, 10);
        check("stats_stall", stallCntA, 3);
        check("stats_stall_b", stallCntB, 1);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
